// File: rtl/lsu_bus_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_bus_ctrl
//
// Purpose: load/store bus controller sitting after the instruction decoder.
// Takes one memory request at a time. It checks the request's alignment,
// runs a single req/ack data-bus transaction with per-byte write enables, and
// returns aligned, sign- or zero-extended load data to writeback. It stalls the
// pipeline while a transaction is open.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   When defined, a BUSY cycle counter aborts a transaction that receives no
//   ack within TIMEOUT_CYCLES cycles, and bus_err_out pulses for one cycle.
//   When undefined, BUSY waits indefinitely and bus_err_out is tied to 0.
//
// Parameters:
//   TIMEOUT_CYCLES   BUSY cycles without ack before abort (LSU_TIMEOUT_EN only)
//
// Ports:
//   clk_in, rst_n_in        clock (rising edge), asynchronous active-low reset
//   mem_wr_req_in           store request (wins when both requests are high)
//   mem_rd_req_in           load request
//   load_size_in[1:0]       00 byte, 01 half, 10 word, 11 reserved
//   load_unsigned_in        1 = zero-extend the load result
//   flush_in                kills a pending request or load result
//   addr_in[31:0]           effective address
//   wdata_in[31:0]          store data
//   dbus_req_out            bus request, held until ack
//   dbus_wr_out             1 = write cycle
//   dbus_addr_out[31:0]     word-aligned address
//   dbus_wdata_out[31:0]    lane-replicated store data
//   dbus_wmask_out[3:0]     byte enables, 0000 on reads
//   dbus_ack_in             bus completion, rdata valid in the same cycle
//   dbus_rdata_in[31:0]     read data word
//   stall_out               hold the upstream pipeline
//   load_data_out[31:0]     extended load result (holds between strobes)
//   load_valid_out          one-cycle strobe, load_data_out valid
//   misaligned_out          one-cycle strobe, request rejected
//   bus_err_out             one-cycle strobe, timeout abort
//
// Bus handshake: dbus_req_out rises the cycle after a request is accepted.
// It stays high, together with stable dbus_wr/addr/wdata/wmask, up to and
// including the first cycle in which dbus_ack_in is high. That cycle completes
// the transfer; for reads, dbus_rdata_in is sampled in that same cycle.
// -----------------------------------------------------------------------------
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        mem_wr_req_in,
  input  logic        mem_rd_req_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic        flush_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        dbus_req_out,
  output logic        dbus_wr_out,
  output logic [31:0] dbus_addr_out,
  output logic [31:0] dbus_wdata_out,
  output logic [3:0]  dbus_wmask_out,
  input  logic        dbus_ack_in,
  input  logic [31:0] dbus_rdata_in,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("lsu_bus_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        wr_q, wr_d;
  logic        kill_q, kill_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] load_data_q, load_data_d;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             timeout;
  // The last no-ack BUSY cycle is the one where the count reaches TIMEOUT_CYCLES-1.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Request decode
  logic        req_any;
  logic        aligned;
  logic        accept;
  logic        reject;
  logic [3:0]  st_mask;
  logic [31:0] st_data;

  always_comb begin
    req_any = mem_wr_req_in | mem_rd_req_in;
    aligned = 1'b0;
    st_mask = 4'b1111;
    st_data = wdata_in;
    case (load_size_in)
      2'b00: begin
        aligned = 1'b1;
        st_mask = 4'b0001 << addr_in[1:0];
        st_data = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        aligned = ~addr_in[0];
        st_mask = 4'b0011 << {addr_in[1], 1'b0};
        st_data = {2{wdata_in[15:0]}};
      end
      2'b10: begin
        aligned = (addr_in[1:0] == 2'b00);
      end
      default: aligned = 1'b0;  // reserved size is always rejected
    endcase
    accept = (state_q == ST_IDLE) & req_any & ~flush_in & aligned;
    reject = (state_q == ST_IDLE) & req_any & ~flush_in & ~aligned;
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  logic [31:0] shifted;
  logic [31:0] ext_data;

  always_comb begin
    shifted = dbus_rdata_in >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   ext_data = uns_q ? {24'b0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ext_data = uns_q ? {16'b0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default: ext_data = shifted;  // word loads are aligned, so no shift occurs
    endcase
  end

  // Next state and datapath
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wr_d         = wr_q;
    kill_d       = kill_q;
    misaligned_d = reject;
    load_data_d  = load_data_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt_q;
    bus_err_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
          addr_d  = addr_in;
          wdata_d = st_data;
          wr_d    = mem_wr_req_in;
          wmask_d = mem_wr_req_in ? st_mask : 4'b0000;
          size_d  = load_size_in;
          uns_d   = load_unsigned_in;
          kill_d  = 1'b0;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      ST_BUSY: begin
        // A flush never aborts the handshake; it only marks the result as dead.
        kill_d = kill_q | flush_in;
        if (dbus_ack_in) begin
          if (wr_q || kill_q || flush_in) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_DONE;
            load_data_d = ext_data;
          end
        end
`ifdef LSU_TIMEOUT_EN
        else if (timeout) begin
          state_d   = ST_IDLE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      wr_q         <= 1'b0;
      kill_q       <= 1'b0;
      misaligned_q <= 1'b0;
      load_data_q  <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= '0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wr_q         <= wr_d;
      kill_q       <= kill_d;
      misaligned_q <= misaligned_d;
      load_data_q  <= load_data_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= cnt_d;
      bus_err_q    <= bus_err_d;
`endif
    end
  end

  // Outputs
  assign dbus_req_out   = (state_q == ST_BUSY);
  assign dbus_wr_out    = wr_q;
  assign dbus_addr_out  = {addr_q[31:2], 2'b00};
  assign dbus_wdata_out = wdata_q;
  assign dbus_wmask_out = wmask_q;
  // Stall drops in DONE, the cycle in which the load result is presented.
  assign stall_out      = accept | (state_q == ST_BUSY);
  assign load_valid_out = (state_q == ST_DONE) & ~flush_in;
  assign load_data_out  = load_data_q;
  assign misaligned_out = misaligned_q;
`ifdef LSU_TIMEOUT_EN
  assign bus_err_out    = bus_err_q;
`else
  assign bus_err_out    = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_bus_ctrl
//
// Bench for lsu_bus_ctrl. A transaction-level model follows each request from
// acceptance to completion and predicts every output on each falling edge.
// Directed sequences add hand-computed literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_lsu_bus_ctrl;

  localparam int TB_TIMEOUT = 4;

  // Clock / reset
  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        mem_wr_req_in, mem_rd_req_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in, flush_in;
  logic [31:0] addr_in, wdata_in;
  logic        dbus_req_out, dbus_wr_out;
  logic [31:0] dbus_addr_out, dbus_wdata_out;
  logic [3:0]  dbus_wmask_out;
  logic        dbus_ack_in;
  logic [31:0] dbus_rdata_in;
  logic        stall_out;
  logic [31:0] load_data_out;
  logic        load_valid_out, misaligned_out, bus_err_out;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .mem_wr_req_in    (mem_wr_req_in),
    .mem_rd_req_in    (mem_rd_req_in),
    .load_size_in     (load_size_in),
    .load_unsigned_in (load_unsigned_in),
    .flush_in         (flush_in),
    .addr_in          (addr_in),
    .wdata_in         (wdata_in),
    .dbus_req_out     (dbus_req_out),
    .dbus_wr_out      (dbus_wr_out),
    .dbus_addr_out    (dbus_addr_out),
    .dbus_wdata_out   (dbus_wdata_out),
    .dbus_wmask_out   (dbus_wmask_out),
    .dbus_ack_in      (dbus_ack_in),
    .dbus_rdata_in    (dbus_rdata_in),
    .stall_out        (stall_out),
    .load_data_out    (load_data_out),
    .load_valid_out   (load_valid_out),
    .misaligned_out   (misaligned_out),
    .bus_err_out      (bus_err_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding bus transaction plus pending one-cycle strobes
  logic        m_open, m_killed, m_due, m_misal, m_err;
  logic        m_wr, m_uns;
  logic [1:0]  m_size, m_off;
  logic [31:0] m_addr, m_wdata, m_load_data;
  logic [3:0]  m_mask;
  int          m_waited;
  logic        t_rq, t_idle, t_al, t_acc;
  int          t_off;

  function automatic logic [31:0] m_extract(input logic [31:0] rd, input logic [1:0] off,
                                            input logic [1:0] size, input logic uns);
    logic [31:0] v;
    v = rd >> (8 * off);
    if (size == 2'd0)      v = (uns || !v[7])  ? (v & 32'h0000_00FF) : (v | 32'hFFFF_FF00);
    else if (size == 2'd1) v = (uns || !v[15]) ? (v & 32'h0000_FFFF) : (v | 32'hFFFF_0000);
    else                   v = rd;
    return v;
  endfunction

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      m_open = 0; m_killed = 0; m_due = 0; m_misal = 0; m_err = 0;
      m_load_data = '0; m_waited = 0;
      chk("rst_req", {31'b0, dbus_req_out}, 0);
      chk("rst_stall", {31'b0, stall_out}, 0);
      chk("rst_valid", {31'b0, load_valid_out}, 0);
      chk("rst_misal", {31'b0, misaligned_out}, 0);
      chk("rst_buserr", {31'b0, bus_err_out}, 0);
      chk("rst_ldata", load_data_out, 0);
      chk("rst_wmask", {28'b0, dbus_wmask_out}, 0);
    end else begin
      t_rq   = mem_wr_req_in | mem_rd_req_in;
      t_idle = !m_open && !m_due;
      t_off  = int'(addr_in[1:0]);
      t_al   = (load_size_in != 2'd3) && ((t_off % (1 << load_size_in)) == 0);
      t_acc  = t_idle && t_rq && !flush_in && t_al;

      chk("stall", {31'b0, stall_out}, {31'b0, t_acc | m_open});
      chk("req", {31'b0, dbus_req_out}, {31'b0, m_open});
      if (m_open) begin
        chk("wr", {31'b0, dbus_wr_out}, {31'b0, m_wr});
        chk("addr", dbus_addr_out, m_addr);
        chk("wmask", {28'b0, dbus_wmask_out}, {28'b0, m_mask});
        if (m_wr) chk("wdata", dbus_wdata_out, m_wdata);
      end
      chk("valid", {31'b0, load_valid_out}, {31'b0, m_due & ~flush_in});
      chk("ldata", load_data_out, m_load_data);
      chk("misal", {31'b0, misaligned_out}, {31'b0, m_misal});
      chk("buserr", {31'b0, bus_err_out}, {31'b0, m_err});

      // advance the model to the next cycle
      m_misal = t_idle && t_rq && !flush_in && !t_al;
      m_err   = 0;
      m_due   = 0;
      if (t_acc) begin
        m_open = 1; m_killed = 0; m_waited = 0;
        m_wr   = mem_wr_req_in;
        m_size = load_size_in; m_uns = load_unsigned_in; m_off = addr_in[1:0];
        m_addr = addr_in & 32'hFFFF_FFFC;
        if (!m_wr)                  m_mask = 4'b0000;
        else if (m_size == 2'd0)    m_mask = 4'(1 << t_off);
        else if (m_size == 2'd1)    m_mask = 4'(3 << t_off);
        else                        m_mask = 4'hF;
        if (m_size == 2'd0)      m_wdata = 32'(wdata_in[7:0]) * 32'h0101_0101;
        else if (m_size == 2'd1) m_wdata = 32'(wdata_in[15:0]) * 32'h0001_0001;
        else                     m_wdata = wdata_in;
      end else if (m_open) begin
        if (flush_in) m_killed = 1;
        if (dbus_ack_in) begin
          m_open = 0;
          if (!m_wr && !m_killed) begin
            m_load_data = m_extract(dbus_rdata_in, m_off, m_size, m_uns);
            m_due = 1;
          end
        end else begin
          m_waited++;
`ifdef LSU_TIMEOUT_EN
          if (m_waited == TB_TIMEOUT) begin
            m_open = 0;
            m_err  = 1;
          end
`endif
        end
      end
    end
  end

  // Driver tasks: all stimulus changes 2 time units after a rising edge
  task automatic drive_idle();
    mem_wr_req_in = 0; mem_rd_req_in = 0; load_size_in = 2'd0; load_unsigned_in = 0;
    flush_in = 0; addr_in = '0; wdata_in = '0; dbus_ack_in = 0; dbus_rdata_in = '0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  // Present a request for one cycle; returns 2 units into the following cycle.
  task automatic issue(input logic wr, input logic rd, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    mem_wr_req_in = wr; mem_rd_req_in = rd; load_size_in = size;
    load_unsigned_in = uns; addr_in = addr; wdata_in = wdata;
    step(1);
    mem_wr_req_in = 0; mem_rd_req_in = 0;
  endtask

  // Hold off ack for 'waits' cycles, then ack for one cycle with rdata.
  task automatic ack_after(input int waits, input logic [31:0] rdata);
    step(waits);
    dbus_ack_in = 1; dbus_rdata_in = rdata;
    step(1);
    dbus_ack_in = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    drive_idle();
    #2;
    chk("reset_stall", {31'b0, stall_out}, 0);
    chk("reset_ldata", load_data_out, 0);
    repeat (3) @(posedge clk_in);
    #2 rst_n_in = 1;
    step(1);

    // SB 0x103: lane 3 enabled, replicated data, word address
    issue(1, 0, 2'd0, 0, 32'h0000_0103, 32'h0000_00A5);
    @(negedge clk_in);
    chk("sb_wmask", {28'b0, dbus_wmask_out}, 32'h8);
    chk("sb_wdata", dbus_wdata_out, 32'hA5A5_A5A5);
    chk("sb_addr", dbus_addr_out, 32'h0000_0100);
    ack_after(1, 32'h0);
    @(negedge clk_in);
    chk("sb_stall_released", {31'b0, stall_out}, 0);
    step(1);

    // LH 0x202 signed, ack after 3 waits
    issue(0, 1, 2'd1, 0, 32'h0000_0202, 32'h0);
    ack_after(3, 32'h8001_1234);
    @(negedge clk_in);
    chk("lh_valid", {31'b0, load_valid_out}, 1);
    chk("lh_data", load_data_out, 32'hFFFF_8001);
    step(1);
    chk("lh_valid_once", {31'b0, load_valid_out}, 0);

    // LW 0x301 rejected, then LB 0x301 in the very next cycle
    issue(0, 1, 2'd2, 0, 32'h0000_0301, 32'h0);
    mem_rd_req_in = 1; load_size_in = 2'd0; load_unsigned_in = 0; addr_in = 32'h0000_0301;
    @(negedge clk_in);
    chk("lw_misal", {31'b0, misaligned_out}, 1);
    chk("lw_no_req", {31'b0, dbus_req_out}, 0);
    chk("lb_accept_stall", {31'b0, stall_out}, 1);
    step(1);
    mem_rd_req_in = 0;
    ack_after(0, 32'h1122_F344);
    @(negedge clk_in);
    chk("lb_data", load_data_out, 32'hFFFF_FFF3);
    step(1);

    // LBU with flush during BUSY: bus completes, no result
    issue(0, 1, 2'd0, 1, 32'h0000_0102, 32'h0);
    flush_in = 1;
    step(1);
    flush_in = 0;
    ack_after(2, 32'h00AB_0000);
    @(negedge clk_in);
    chk("flush_no_valid", {31'b0, load_valid_out}, 0);
    chk("flush_ldata_held", load_data_out, 32'hFFFF_FFF3);
    step(1);
    issue(1, 0, 2'd2, 0, 32'h0000_0400, 32'hDEAD_BEEF);
    @(negedge clk_in);
    chk("sw_after_flush_req", {31'b0, dbus_req_out}, 1);
    chk("sw_wdata", dbus_wdata_out, 32'hDEAD_BEEF);
    step(1);
    ack_after(0, 32'h0);

    // Both requests high -> SH
    issue(1, 1, 2'd1, 0, 32'h0000_00A2, 32'h1234_BEEF);
    @(negedge clk_in);
    chk("sh_wr", {31'b0, dbus_wr_out}, 1);
    chk("sh_wmask", {28'b0, dbus_wmask_out}, 32'hC);
    chk("sh_wdata", dbus_wdata_out, 32'hBEEF_BEEF);
    step(1);
    ack_after(1, 32'h0);

    // LHU with flush in DONE: strobe suppressed
    issue(0, 1, 2'd1, 1, 32'h0000_00A2, 32'h0);
    ack_after(0, 32'h8001_1234);
    flush_in = 1;
    @(negedge clk_in);
    chk("done_flush_valid", {31'b0, load_valid_out}, 0);
    chk("lhu_data", load_data_out, 32'h0000_8001);
    step(1);
    flush_in = 0;

    // Reserved size rejected; flushed request ignored
    issue(0, 1, 2'd3, 0, 32'h0000_0700, 32'h0);
    @(negedge clk_in);
    chk("size11_misal", {31'b0, misaligned_out}, 1);
    step(1);
    flush_in = 1;
    issue(1, 0, 2'd2, 0, 32'h0000_0800, 32'h5555_AAAA);
    flush_in = 0;
    @(negedge clk_in);
    chk("idle_flush_no_req", {31'b0, dbus_req_out}, 0);
    step(1);

    // Reset asserted mid-BUSY
    issue(0, 1, 2'd2, 0, 32'h0000_0500, 32'h0);
    #1 rst_n_in = 0;
    #1;
    chk("arst_req", {31'b0, dbus_req_out}, 0);
    chk("arst_stall", {31'b0, stall_out}, 0);
    chk("arst_addr", dbus_addr_out, 0);
    chk("arst_ldata", load_data_out, 0);
    step(2);
    rst_n_in = 1;
    step(3);

`ifdef LSU_TIMEOUT_EN
    issue(0, 1, 2'd2, 0, 32'h0000_0600, 32'h0);
    step(4);
    @(negedge clk_in);
    chk("to_buserr", {31'b0, bus_err_out}, 1);
    chk("to_req_dropped", {31'b0, dbus_req_out}, 0);
    step(1);
    issue(0, 1, 2'd2, 0, 32'h0000_0604, 32'h0);
    ack_after(3, 32'hCAFE_BABE);
    @(negedge clk_in);
    chk("to_edge_valid", {31'b0, load_valid_out}, 1);
    chk("to_edge_data", load_data_out, 32'hCAFE_BABE);
    step(1);
`else
    issue(0, 1, 2'd2, 0, 32'h0000_0600, 32'h0);
    step(20);
    chk("no_timeout_req", {31'b0, dbus_req_out}, 1);
    ack_after(0, 32'hCAFE_BABE);
    @(negedge clk_in);
    chk("late_ack_data", load_data_out, 32'hCAFE_BABE);
    step(1);
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
